// File: rtl/fpnew_pkg.sv
// Shared constants and types for the FP result retire logic.
package fpnew_pkg;

    localparam int unsigned STATUS_WIDTH = 5;

    typedef enum logic {
        IN_ORDER    = 1'b0,
        ROUND_ROBIN = 1'b1
    } retire_mode_e;

endpackage

// File: rtl/fpnew_order_fifo.sv
// Order FIFO holding the target opgroup of every issued operation.
module fpnew_order_fifo #(
    parameter int Depth     = 8,
    parameter int DataWidth = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [DataWidth-1:0]         data_i,
    input  logic                         pop_i,
    output logic [DataWidth-1:0]         data_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth+1);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/fpnew_inorder_retire.sv
// Retires opgroup results either in issue order or round-robin, with a
// zero-latency combinational output mux.
module fpnew_inorder_retire
    import fpnew_pkg::*;
#(
    parameter int NumOpGroups = 5,
    parameter int Width       = 64,
    parameter int Depth       = 8,
    parameter int TagWidth    = 1,
    parameter int OutOfOrder  = 0
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        issue_valid_i,
    output logic                                        issue_ready_o,
    input  logic [$clog2(NumOpGroups)-1:0]              issue_opgrp_i,
    input  logic [NumOpGroups-1:0]                      grp_valid_i,
    output logic [NumOpGroups-1:0]                      grp_ready_o,
    input  logic [NumOpGroups-1:0][Width-1:0]           grp_result_i,
    input  logic [NumOpGroups-1:0][STATUS_WIDTH-1:0]    grp_status_i,
    input  logic [NumOpGroups-1:0][TagWidth-1:0]        grp_tag_i,
    output logic                                        out_valid_o,
    input  logic                                        out_ready_i,
    output logic [Width-1:0]                            result_o,
    output logic [STATUS_WIDTH-1:0]                     status_o,
    output logic [TagWidth-1:0]                         tag_o,
    input  logic                                        flush_i,
    output logic                                        busy_o,
    output logic [$clog2(Depth+1)-1:0]                  inflight_o,
    output logic                                        issue_err_o
);

    localparam int GrpW = $clog2(NumOpGroups);
    localparam int CntW = $clog2(Depth+1);
    localparam retire_mode_e Mode = (OutOfOrder != 0) ? ROUND_ROBIN : IN_ORDER;

    logic [GrpW-1:0] head_grp, sel_grp, cand, rr_q;
    logic [CntW-1:0] count;
    logic            fifo_empty, grant_found;
    logic            issue_hs, bad_grp, push, pop;

    assign issue_ready_o = (count < CntW'(Depth)) && !flush_i;
    assign issue_hs      = issue_valid_i && issue_ready_o;
    assign bad_grp       = (int'(issue_opgrp_i) >= NumOpGroups);
    assign push          = issue_hs && !bad_grp;
    assign pop           = out_valid_o && out_ready_i;

    fpnew_order_fifo #(
        .Depth     (Depth),
        .DataWidth (GrpW)
    ) u_order_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (push),
        .data_i  (issue_opgrp_i),
        .pop_i   (pop),
        .data_o  (head_grp),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    // In round-robin mode the FIFO contents are ignored; only its count gates retire.
    always_comb begin
        sel_grp     = head_grp;
        cand        = '0;
        grant_found = 1'b0;
        if (Mode == ROUND_ROBIN) begin
            sel_grp = '0;
            for (int i = 0; i < NumOpGroups; i++) begin
                cand = GrpW'((int'(rr_q) + i) % NumOpGroups);
                if (!grant_found && grp_valid_i[cand]) begin
                    grant_found = 1'b1;
                    sel_grp     = cand;
                end
            end
        end else begin
            grant_found = grp_valid_i[head_grp];
        end
    end

    assign out_valid_o = !fifo_empty && grant_found && !flush_i;

    always_comb begin
        grp_ready_o = '0;
        if (pop) grp_ready_o[sel_grp] = 1'b1;
    end

    assign result_o   = out_valid_o ? grp_result_i[sel_grp] : '0;
    assign status_o   = out_valid_o ? grp_status_i[sel_grp] : '0;
    assign tag_o      = out_valid_o ? grp_tag_i[sel_grp]    : '0;
    assign busy_o     = (count != '0);
    assign inflight_o = count;

    // rr_q holds the group where the next search starts.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rr_q <= '0;
        end else if (pop && (Mode == ROUND_ROBIN)) begin
            rr_q <= (int'(sel_grp) == NumOpGroups - 1) ? '0 : sel_grp + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) issue_err_o <= 1'b0;
        else       issue_err_o <= issue_hs && bad_grp;
    end

endmodule

// File: tb/tb_fpnew_inorder_retire.sv
// Bench for fpnew_inorder_retire: in-order and round-robin instances checked
// every cycle against a queue/counter model, plus directed scenarios.
module tb_fpnew_inorder_retire;

    localparam int N = 5;
    localparam int D = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_valid;
    logic [2:0]        issue_opgrp;
    logic [N-1:0]      grp_valid;
    logic [N-1:0][63:0] grp_result;
    logic [N-1:0][4:0] grp_status;
    logic [N-1:0][0:0] grp_tag;
    logic              out_ready;
    logic              flush;

    logic              irdy [2];
    logic              ovld [2];
    logic [N-1:0]      grdy [2];
    logic [63:0]       res  [2];
    logic [4:0]        st   [2];
    logic [0:0]        tg   [2];
    logic              busy [2];
    logic [3:0]        infl [2];
    logic              err  [2];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fpnew_inorder_retire #(.NumOpGroups(N), .Width(64), .Depth(D), .TagWidth(1), .OutOfOrder(0)) dut_io (
        .clk_i(clk), .rst_i(rst), .issue_valid_i(issue_valid), .issue_ready_o(irdy[0]),
        .issue_opgrp_i(issue_opgrp), .grp_valid_i(grp_valid), .grp_ready_o(grdy[0]),
        .grp_result_i(grp_result), .grp_status_i(grp_status), .grp_tag_i(grp_tag),
        .out_valid_o(ovld[0]), .out_ready_i(out_ready), .result_o(res[0]), .status_o(st[0]),
        .tag_o(tg[0]), .flush_i(flush), .busy_o(busy[0]), .inflight_o(infl[0]), .issue_err_o(err[0]));

    fpnew_inorder_retire #(.NumOpGroups(N), .Width(64), .Depth(D), .TagWidth(1), .OutOfOrder(1)) dut_rr (
        .clk_i(clk), .rst_i(rst), .issue_valid_i(issue_valid), .issue_ready_o(irdy[1]),
        .issue_opgrp_i(issue_opgrp), .grp_valid_i(grp_valid), .grp_ready_o(grdy[1]),
        .grp_result_i(grp_result), .grp_status_i(grp_status), .grp_tag_i(grp_tag),
        .out_valid_o(ovld[1]), .out_ready_i(out_ready), .result_o(res[1]), .status_o(st[1]),
        .tag_o(tg[1]), .flush_i(flush), .busy_o(busy[1]), .inflight_o(infl[1]), .issue_err_o(err[1]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: in-order keeps a queue of issued groups; round-robin keeps a count
    // and the last granted group.
    int  q_io[$];
    int  cnt_rr;
    int  last_rr;
    bit  err_exp [2];
    bit  armed = 1'b0;

    task automatic model_cycle();
        for (int d = 0; d < 2; d++) begin
            string nm;
            int    size, g;
            bit    e_rdy, e_vld, hs;
            logic [N-1:0] e_grdy;
            logic [63:0]  e_res;
            logic [4:0]   e_st;
            logic [0:0]   e_tg;
            nm    = (d == 0) ? "io" : "rr";
            size  = (d == 0) ? q_io.size() : cnt_rr;
            e_rdy = (size < D) && !flush;
            g     = -1;
            if (d == 0) begin
                if (size > 0) g = q_io[0];
                e_vld = (g >= 0) && grp_valid[g] && !flush;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (last_rr + 1 + k) % N;
                    if (g < 0 && grp_valid[c]) g = c;
                end
                e_vld = (size > 0) && (g >= 0) && !flush;
            end
            e_grdy = '0; e_res = '0; e_st = '0; e_tg = '0;
            if (e_vld) begin
                e_res = grp_result[g]; e_st = grp_status[g]; e_tg = grp_tag[g];
                if (out_ready) e_grdy[g] = 1'b1;
            end
            if (armed) begin
                chk({nm, ".issue_ready"}, 64'(irdy[d]), 64'(e_rdy));
                chk({nm, ".out_valid"},   64'(ovld[d]), 64'(e_vld));
                chk({nm, ".grp_ready"},   64'(grdy[d]), 64'(e_grdy));
                chk({nm, ".result"},      res[d],       e_res);
                chk({nm, ".status"},      64'(st[d]),   64'(e_st));
                chk({nm, ".tag"},         64'(tg[d]),   64'(e_tg));
                chk({nm, ".inflight"},    64'(infl[d]), 64'(size));
                chk({nm, ".busy"},        64'(busy[d]), 64'(size != 0));
                chk({nm, ".issue_err"},   64'(err[d]),  64'(err_exp[d]));
            end
            if (rst || flush) begin
                if (d == 0) q_io.delete();
                else begin cnt_rr = 0; last_rr = -1; end
                err_exp[d] = 1'b0;
            end else begin
                hs = issue_valid && e_rdy;
                if (e_vld && out_ready) begin
                    if (d == 0) void'(q_io.pop_front());
                    else begin cnt_rr--; last_rr = g; end
                end
                if (hs && issue_opgrp < N) begin
                    if (d == 0) q_io.push_back(int'(issue_opgrp));
                    else cnt_rr++;
                end
                err_exp[d] = hs && (issue_opgrp >= N);
            end
        end
        if (rst) armed = 1'b1;
    endtask

    initial begin
        cnt_rr = 0; last_rr = -1;
        forever begin
            @(negedge clk);
            #2;
            model_cycle();
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_opgrp = '0; grp_valid = '0;
        out_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        step(); rst = 1'b1; idle_inputs();
        step(); rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] rr_exp [4];
        rst = 1'b1; idle_inputs();
        grp_result = '0; grp_status = '0; grp_tag = '0;

        // Reset state with stray results on every group
        do_reset();
        grp_valid = '1; out_ready = 1'b1;
        for (int g = 0; g < N; g++) grp_result[g] = {$urandom, $urandom};
        #3;
        chk("rst.issue_ready", 64'(irdy[0]), 64'd1);
        chk("rst.out_valid",   64'(ovld[0]), 64'd0);
        chk("rst.grp_ready",   64'(grdy[0]), 64'd0);
        chk("rst.busy",        64'(busy[0]), 64'd0);
        chk("rst.inflight",    64'(infl[0]), 64'd0);
        chk("rst.issue_err",   64'(err[0]),  64'd0);
        chk("rst.result",      res[0],       64'd0);
        chk("rst.status",      64'(st[0]),   64'd0);
        chk("rst.rr_out_valid", 64'(ovld[1]), 64'd0);

        // In-order: issue 2,0,1 while groups 0 and 1 are already valid
        for (int g = 0; g < N; g++) begin
            grp_result[g] = 64'h100 + 64'(g);
            grp_status[g] = 5'(g);
            grp_tag[g]    = 1'(g);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            issue_valid = 1'b1;
            issue_opgrp = (i == 0) ? 3'd2 : (i == 1) ? 3'd0 : 3'd1;
            grp_valid   = 5'b00011;
            #3 chk("ord.wait_valid", 64'(ovld[0]), 64'd0);
        end
        step(); issue_valid = 1'b0;
        #3 chk("ord.inflight3", 64'(infl[0]), 64'd3);
        chk("ord.no_retire", 64'(ovld[0]), 64'd0);
        step(); grp_valid = 5'b00111;
        #3 chk("ord.res0", res[0], 64'h102);
        chk("ord.rdy0", 64'(grdy[0]), 64'b00100);
        chk("ord.st0", 64'(st[0]), 64'd2);
        step(); #3 chk("ord.res1", res[0], 64'h100);
        chk("ord.rdy1", 64'(grdy[0]), 64'b00001);
        step(); #3 chk("ord.res2", res[0], 64'h101);
        chk("ord.rdy2", 64'(grdy[0]), 64'b00010);
        chk("ord.tag2", 64'(tg[0]), 64'd1);
        step(); #3 chk("ord.drained_valid", 64'(ovld[0]), 64'd0);
        chk("ord.drained_inflight", 64'(infl[0]), 64'd0);

        // Full FIFO rejects issue even while retiring
        do_reset(); out_ready = 1'b1;
        for (int i = 0; i < D; i++) begin
            step(); issue_valid = 1'b1; issue_opgrp = 3'(i % N);
        end
        step(); issue_valid = 1'b0;
        #3 chk("full.issue_ready", 64'(irdy[0]), 64'd0);
        chk("full.inflight8", 64'(infl[0]), 64'd8);
        step(); issue_valid = 1'b1; issue_opgrp = 3'd1; grp_valid = 5'b00001;
        #3 chk("full.reject", 64'(irdy[0]), 64'd0);
        chk("full.retire", 64'(ovld[0]), 64'd1);
        step(); issue_valid = 1'b0; grp_valid = '0;
        #3 chk("full.inflight7", 64'(infl[0]), 64'd7);
        chk("full.ready_again", 64'(irdy[0]), 64'd1);

        // Backpressure on head group 1
        step(); grp_valid = 5'b00010; out_ready = 1'b0;
        grp_result[1] = 64'hdead_beef_0000_0001;
        for (int k = 0; k < 3; k++) begin
            #3;
            chk("bp.valid", 64'(ovld[0]), 64'd1);
            chk("bp.result", res[0], 64'hdead_beef_0000_0001);
            chk("bp.grp_ready", 64'(grdy[0]), 64'd0);
            chk("bp.inflight", 64'(infl[0]), 64'd7);
            step();
        end
        out_ready = 1'b1;
        #3 chk("bp.release", 64'(grdy[0]), 64'b00010);

        // Flush with 4 in flight
        do_reset(); out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); issue_valid = 1'b1; issue_opgrp = 3'(i);
        end
        step(); flush = 1'b1; grp_valid = '1; issue_opgrp = 3'd0;
        #3 chk("flush.valid", 64'(ovld[0]), 64'd0);
        chk("flush.grp_ready", 64'(grdy[0]), 64'd0);
        chk("flush.issue_ready", 64'(irdy[0]), 64'd0);
        chk("flush.inflight4", 64'(infl[0]), 64'd4);
        step(); flush = 1'b0; issue_valid = 1'b0; grp_valid = '0;
        #3 chk("flush.inflight0", 64'(infl[0]), 64'd0);
        chk("flush.busy", 64'(busy[0]), 64'd0);

        // Bad opgroup
        step(); issue_valid = 1'b1; issue_opgrp = 3'd3;
        step(); issue_opgrp = 3'd6;
        #3 chk("bad.err_before", 64'(err[0]), 64'd0);
        chk("bad.inflight_before", 64'(infl[0]), 64'd1);
        step(); issue_valid = 1'b0;
        #3 chk("bad.err_pulse", 64'(err[0]), 64'd1);
        chk("bad.inflight_after", 64'(infl[0]), 64'd1);
        step(); #3 chk("bad.err_clear", 64'(err[0]), 64'd0);

        // Round-robin between groups 0 and 3
        do_reset(); out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); issue_valid = 1'b1; issue_opgrp = 3'd2;
        end
        step(); issue_valid = 1'b0; grp_valid = 5'b01001;
        rr_exp[0] = 5'b00001; rr_exp[1] = 5'b01000;
        rr_exp[2] = 5'b00001; rr_exp[3] = 5'b01000;
        for (int k = 0; k < 4; k++) begin
            #3 chk("rr.grant", 64'(grdy[1]), 64'(rr_exp[k]));
            step();
        end
        grp_valid = '0;

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 2500; n++) begin
            step();
            rst         = ($urandom % 300) == 0;
            flush       = ($urandom % 40) == 0;
            issue_valid = ($urandom % 3) != 0;
            issue_opgrp = (($urandom % 10) == 0) ? 3'(5 + $urandom % 3) : 3'($urandom % N);
            grp_valid   = 5'($urandom);
            out_ready   = ($urandom % 4) != 0;
            for (int g = 0; g < N; g++) begin
                grp_result[g] = {$urandom, $urandom};
                grp_status[g] = 5'($urandom);
                grp_tag[g]    = 1'($urandom);
            end
        end
        step(); idle_inputs(); rst = 1'b0;
        step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
